// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates the fetch stage and the load/store stage onto the
// single shared memory port. Only one transaction is in flight at a time
// (IDLE -> REQ -> RESP). Data requests normally win. A streak counter gives
// fetch a turn after MAX_D_STREAK back-to-back data grants made while fetch
// was waiting. A flush kills the response of an in-flight fetch.
module mem_port_arb #(
  parameter int ADDR_W       = 48,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                flush,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [31:0]         if_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                kill_q, kill_d;
  logic                owner_f_q, owner_f_d;   // 1 = fetch owns the transaction
  logic                wsel_q, wsel_d;         // which 32-bit half holds the instruction
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                f_pend;
  logic                streak_sat;
  logic                d_win;
  logic                f_win;

  // Arbitration: a flush in IDLE hides if_req for that cycle; fetch only
  // overrides data once the streak has saturated.
  always_comb begin
    f_pend     = if_req && !flush;
    streak_sat = (streak_q == STREAK_W'(MAX_D_STREAK));
    d_win      = (state_q == IDLE) && d_req && !(f_pend && streak_sat);
    f_win      = (state_q == IDLE) && f_pend && (!d_req || streak_sat);
  end

  // Next-state, grants, memory request capture and response routing.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    owner_f_d   = owner_f_q;
    wsel_d      = wsel_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_be_d      = m_be_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (d_win) begin
          d_gnt     = 1'b1;
          owner_f_d = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          // Only grants that made fetch wait count towards the streak.
          if (f_pend) begin
            streak_d = streak_sat ? streak_q : streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
          state_d = REQ;
        end else if (f_win) begin
          if_gnt    = 1'b1;
          owner_f_d = 1'b1;
          wsel_d    = if_addr[2];
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
          streak_d  = '0;
          state_d   = REQ;
        end
      end

      REQ: begin
        if (flush && owner_f_q) begin
          kill_d = 1'b1;
        end
        if (m_gnt) begin
          m_req_d = 1'b0;
          state_d = RESP;
        end
      end

      RESP: begin
        if (flush && owner_f_q) begin
          kill_d = 1'b1;
        end
        if (m_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (owner_f_q) begin
            // A flush now or earlier in this transaction drops the fetch.
            if (!kill_q && !flush) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = wsel_q ? m_rdata[63:32] : m_rdata[31:0];
            end
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset abandons any transaction.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      owner_f_q   <= 1'b0;
      wsel_q      <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_be_q      <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      owner_f_q   <= owner_f_d;
      wsel_q      <= wsel_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_be_q      <= m_be_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed testbench for mem_port_arb: single fetch, contention fairness,
// flush kill, memory backpressure, flush in IDLE and async reset in RESP.
module tb_mem_port_arb;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [7:0]        d_be;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [7:0]        m_be;
  logic              m_gnt, m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(4)) dut (
    .clk(clk), .n_reset(n_reset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Run one full transaction starting in an IDLE cycle where requests are set:
  // grant now, m_gnt next cycle, m_rvalid the cycle after, check at T+3.
  task automatic serve(input string tag, input bit exp_f, input logic [47:0] exp_addr,
                       input logic [63:0] rd, input logic [63:0] exp_rd);
    settle();
    check({tag, ".if_gnt"}, 64'(if_gnt), 64'(exp_f));
    check({tag, ".d_gnt"},  64'(d_gnt),  64'(!exp_f));
    tick();
    m_gnt = 1'b1;
    settle();
    check({tag, ".m_req"},  64'(m_req),  64'd1);
    check({tag, ".m_addr"}, 64'(m_addr), 64'(exp_addr));
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = rd;
    settle();
    check({tag, ".m_req_low"}, 64'(m_req), 64'd0);
    tick();
    m_rvalid = 1'b0;
    settle();
    if (exp_f) begin
      check({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd1);
      check({tag, ".d_rvalid"},  64'(d_rvalid),  64'd0);
      check({tag, ".if_rdata"},  64'(if_rdata),  exp_rd);
    end else begin
      check({tag, ".d_rvalid"},  64'(d_rvalid),  64'd1);
      check({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
      check({tag, ".d_rdata"},   d_rdata,        exp_rd);
    end
    $display("xact %s owner=%s addr=%h rdata=%h", tag, exp_f ? "F" : "D", exp_addr, rd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"},    64'(if_gnt),    64'd0);
    check({tag, ".d_gnt"},     64'(d_gnt),     64'd0);
    check({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
    check({tag, ".if_rdata"},  64'(if_rdata),  64'd0);
    check({tag, ".d_rvalid"},  64'(d_rvalid),  64'd0);
    check({tag, ".d_rdata"},   d_rdata,        64'd0);
    check({tag, ".m_req"},     64'(m_req),     64'd0);
    check({tag, ".m_we"},      64'(m_we),      64'd0);
    check({tag, ".m_addr"},    64'(m_addr),    64'd0);
    check({tag, ".m_wdata"},   m_wdata,        64'd0);
    check({tag, ".m_be"},      64'(m_be),      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi, lo;
    bit          exp_f;

    n_reset  = 1'b0;
    flush    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_be     = '0;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;

    // Reset state
    #2;
    check_all_zero("reset");
    tick();
    tick();
    n_reset = 1'b1;
    tick();

    // Single fetch, upper word selected by if_addr[2]
    if_req  = 1'b1;
    if_addr = 48'h1004;
    serve("fetch1", 1'b1, 48'h1004, 64'hAAAA_BBBB_1111_2222, 64'hAAAA_BBBB);
    if_req = 1'b0;
    tick();
    check("fetch1.pulse", 64'(if_rvalid), 64'd0);
    check("fetch1.hold",  64'(if_rdata),  64'hAAAA_BBBB);

    // Contention: both held high -> D,D,D,D,F repeated
    if_req  = 1'b1;
    if_addr = 48'h3000;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 48'h100;
    for (int i = 0; i < 10; i++) begin
      hi    = 32'h0F0F_0000 + 32'(i);
      lo    = 32'hC0DE_0000 + 32'(i);
      exp_f = ((i % 5) == 4);
      serve($sformatf("cont%0d", i), exp_f, exp_f ? 48'h3000 : 48'h100,
            {hi, lo}, exp_f ? 64'(lo) : {hi, lo});
    end
    if_req = 1'b0;
    d_req  = 1'b0;

    // Flush while fetch is in RESP: response consumed but not forwarded
    tick();
    if_req  = 1'b1;
    if_addr = 48'h2000;
    settle();
    check("kill.if_gnt", 64'(if_gnt), 64'd1);
    tick();
    if_req = 1'b0;
    m_gnt  = 1'b1;
    tick();
    m_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 64'h5555_6666_7777_8888;
    tick();
    m_rvalid = 1'b0;
    settle();
    check("kill.if_rvalid", 64'(if_rvalid), 64'd0);
    check("kill.if_rdata",  64'(if_rdata),  64'hC0DE_0009);
    if_req  = 1'b1;
    if_addr = 48'h2004;
    serve("after_kill", 1'b1, 48'h2004, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678);
    if_req = 1'b0;

    // Flush in the same cycle as m_rvalid suppresses the fetch response
    tick();
    if_req  = 1'b1;
    if_addr = 48'h2008;
    settle();
    check("flrv.if_gnt", 64'(if_gnt), 64'd1);
    tick();
    if_req = 1'b0;
    m_gnt  = 1'b1;
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    flush    = 1'b1;
    m_rdata  = 64'h7777_7777_7777_7777;
    tick();
    m_rvalid = 1'b0;
    flush    = 1'b0;
    settle();
    check("flrv.if_rvalid", 64'(if_rvalid), 64'd0);
    check("flrv.if_rdata",  64'(if_rdata),  64'h1234_5678);

    // Backpressure: data write held for 5 cycles without m_gnt
    tick();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 48'h8000_0010;
    d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    d_be    = 8'hF0;
    settle();
    check("bp.d_gnt", 64'(d_gnt), 64'd1);
    tick();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 48'h0BAD;
    d_wdata = 64'h0;
    d_be    = 8'h00;
    for (int k = 0; k < 6; k++) begin
      m_gnt = (k == 5);
      settle();
      check($sformatf("bp%0d.m_req", k),   64'(m_req),   64'd1);
      check($sformatf("bp%0d.m_we", k),    64'(m_we),    64'd1);
      check($sformatf("bp%0d.m_addr", k),  64'(m_addr),  64'h8000_0010);
      check($sformatf("bp%0d.m_wdata", k), m_wdata,      64'hDEAD_BEEF_CAFE_F00D);
      check($sformatf("bp%0d.m_be", k),    64'(m_be),    64'hF0);
      tick();
    end
    m_gnt = 1'b0;
    settle();
    check("bp.m_req_low", 64'(m_req), 64'd0);
    m_rvalid = 1'b1;
    m_rdata  = 64'h0;
    tick();
    m_rvalid = 1'b0;
    settle();
    check("bp.d_rvalid",  64'(d_rvalid),  64'd1);
    check("bp.if_rvalid", 64'(if_rvalid), 64'd0);
    tick();
    check("bp.pulse", 64'(d_rvalid), 64'd0);
    $display("xact bp owner=D write addr=%h wdata=%h", 48'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D);

    // Flush in IDLE hides if_req for one cycle
    if_req  = 1'b1;
    if_addr = 48'h4000;
    flush   = 1'b1;
    settle();
    check("fidle.if_gnt", 64'(if_gnt), 64'd0);
    check("fidle.d_gnt",  64'(d_gnt),  64'd0);
    tick();
    flush = 1'b0;
    serve("fidle", 1'b1, 48'h4000, 64'h0000_0000_5A5A_A5A5, 64'h5A5A_A5A5);
    if_req = 1'b0;

    // Async reset while in RESP
    tick();
    if_req  = 1'b1;
    if_addr = 48'h1000;
    settle();
    check("rst.if_gnt", 64'(if_gnt), 64'd1);
    tick();
    if_req = 1'b0;
    m_gnt  = 1'b1;
    tick();
    m_gnt = 1'b0;
    settle();
    n_reset = 1'b0;
    settle();
    check_all_zero("rst_mid");
    tick();
    n_reset  = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    m_rvalid = 1'b0;
    settle();
    check("rst.if_rvalid", 64'(if_rvalid), 64'd0);
    check("rst.d_rvalid",  64'(d_rvalid),  64'd0);
    if_req = 1'b1;
    settle();
    check("rst.idle_gnt", 64'(if_gnt), 64'd1);
    if_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer for the single shared memory port of the RV64 core. It sits between the fetch stage, which issues instruction fetches at the current PC, and the memory/load-store stage, which issues data reads and writes. It grants one requester at a time and drives a single-outstanding request/response transaction to memory. Fetch responses are discarded on a mispredict flush, and a streak counter keeps fetch from being starved by data traffic.

## Interface
- ADDR_W, 48, address width (matches PC width)
- DATA_W, 64, memory data width
- MAX_D_STREAK, 4, max consecutive data grants while fetch is waiting

- clk  in  1  clock
- n_reset  in  1  asynchronous, active-low reset
- flush  in  1  mispredict/fence flush from fetch control; kills fetch traffic
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address, word aligned
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch instruction valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address, doubleword aligned
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  read data valid, or write acknowledge
- d_rdata  out  DATA_W  read data
- m_req, m_we  out  1  memory request / write
- m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_be  out  DATA_W/8
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  memory response valid
- m_rdata  in  DATA_W  memory response data

## Operation
- FSM states are IDLE, REQ and RESP. There is exactly one transaction in flight at a time.
- IDLE
  - Arbitration is combinational on the current cycle's requests.
  - The winner receives a one-cycle gnt. Its address and data are registered into the m_* outputs, the owner bit and the fetch word-select (if_addr[2]) are latched, and the FSM moves to REQ.
- REQ
  - m_req=1 and all m_* outputs are held stable until m_gnt=1; m_req is never retracted.
  - On m_gnt the FSM moves to RESP with m_req=0.
- RESP
  - The FSM waits for m_rvalid, forwards the response to the owner, then returns to IDLE.
- Priority
  - Data wins by default.
  - Fetch wins when if_req=1 and streak==MAX_D_STREAK.
- Streak counter
  - It increments on a data grant made while if_req=1, saturating at MAX_D_STREAK.
  - It clears on a fetch grant, and on a data grant made while if_req=0.
- Fetch data: if_rdata = word-select ? m_rdata[63:32] : m_rdata[31:0].
- Writes
  - d_rvalid pulses on m_rvalid as the write acknowledge.
  - d_rdata is don't-care for writes; it is driven with m_rdata.
- Flush
  - If flush=1 in IDLE, if_req is ignored that cycle: no if_gnt, and a data request may still be granted.
  - If flush=1 in REQ or RESP while the owner is fetch, the kill bit is set. The transaction completes on the memory side, but its if_rvalid is suppressed.
  - Flush has no effect on data transactions. kill is cleared on entry to IDLE.
- Flush and m_rvalid in the same cycle: the response is suppressed.
- Reset (async): state=IDLE, streak=0, kill=0. All outputs are 0, including m_req, m_*, gnt, rvalid and rdata.
- Reset mid-transaction abandons it; no rvalid is produced afterwards.

## Timing
- if_gnt and d_gnt are combinational (Mealy) from state, requests, flush and streak, and are asserted only in IDLE.
- For a grant in cycle T: m_req is high from T+1, and remains high through the cycle where m_gnt=1.
- Memory accepting at T+1 with m_rvalid at T+2 gives if_rvalid/d_rvalid registered high at T+3, with IDLE also at T+3.
- Minimum issue-to-issue interval is 3 cycles.
- rvalid outputs are single-cycle pulses, and rdata is held until the next response.

## Test plan
- Single fetch: if_req with if_addr=0x1004; memory gives m_gnt at T+1 and m_rvalid with m_rdata=0xAAAA_BBBB_1111_2222 at T+2 -> if_gnt at T, m_addr=0x1004 at T+1, if_rvalid with if_rdata=0xAAAABBBB at T+3.
- Contention: if_req and d_req held high continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Flush kill: fetch granted, flush pulsed while in RESP -> m_rvalid consumed, if_rvalid stays 0, FSM returns to IDLE, and the next grant is served normally.
- Memory backpressure: a data write is granted and m_gnt is withheld for 5 cycles -> m_req, m_addr, m_wdata and m_be are stable for all 6 cycles; d_rvalid pulses once on m_rvalid.
- Flush in IDLE with if_req=1 and d_req=0 -> no grant that cycle; if_gnt is given the next cycle once flush=0.
- Async reset asserted in RESP -> all outputs 0 immediately; after release, no stale rvalid and the FSM is in IDLE.
